// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - multi-way byte-addressed L1 data array with wrapped read/write and burst line fill
// Registered read port with write-first bypass; fill engine writes one beat per accepted fill_valid.
module cache_data_array #(
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 64,
  parameter int RD_WIDTH   = 64,
  parameter int FILL_WIDTH = 64,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int IW = $clog2(SETS),
  localparam int OW = $clog2(LINE_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [WW-1:0]         rd_way,
  input  logic [IW-1:0]         rd_index,
  input  logic [OW-1:0]         rd_offset,
  output logic [RD_WIDTH-1:0]   rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [WW-1:0]         wr_way,
  input  logic [IW-1:0]         wr_index,
  input  logic [OW-1:0]         wr_offset,
  input  logic [3:0]            wr_size,
  input  logic [63:0]           wr_data,
  input  logic                  fill_start,
  input  logic [WW-1:0]         fill_way,
  input  logic [IW-1:0]         fill_index,
  input  logic                  fill_valid,
  input  logic [FILL_WIDTH-1:0] fill_data,
  output logic                  fill_ready,
  output logic                  fill_done,
  output logic                  busy
);

  localparam int RB    = RD_WIDTH / 8;
  localparam int FB    = FILL_WIDTH / 8;
  localparam int NB    = LINE_BYTES / FB;
  localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = WAYS * SETS * LINE_BYTES;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [7:0]          mem_q [DEPTH];
  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       beat_q, beat_d;
  logic [WW-1:0]       fill_way_q, fill_way_d;
  logic [IW-1:0]       fill_index_q, fill_index_d;
  logic                fill_done_q, fill_done_d;
  logic                rd_valid_q;
  logic [RD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [3:0]          wr_len;
  logic                cpu_we, fill_beat_we;
  int                  wr_line, rd_line, fill_line;
  int                  rd_off, wr_rel;

  function automatic int line_of(input logic [WW-1:0] way, input logic [IW-1:0] idx);
    return ((WAYS > 1) ? int'(way) : 0) * SETS + int'(idx);
  endfunction

  // Byte offsets wrap within the line, so only the low OW bits of off matter.
  function automatic logic [AW-1:0] byte_addr(input int line, input int off);
    return AW'(line * LINE_BYTES + (off & (LINE_BYTES - 1)));
  endfunction

  always_comb begin
    wr_line   = line_of(wr_way, wr_index);
    rd_line   = line_of(rd_way, rd_index);
    fill_line = line_of(fill_way_q, fill_index_q);
    case (wr_size)
      4'd1, 4'd2, 4'd4, 4'd8: wr_len = wr_size;
      default:                wr_len = 4'd0;
    endcase
    // CPU writes into the line under refill would be clobbered by later beats, so drop them.
    cpu_we       = !rst && wr_en && (wr_len != 4'd0) &&
                   !(state_q == ST_FILL && wr_line == fill_line);
    fill_beat_we = !rst && (state_q == ST_FILL) && fill_valid;
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    fill_way_d   = fill_way_q;
    fill_index_d = fill_index_q;
    fill_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d      = ST_FILL;
          beat_d       = '0;
          fill_way_d   = fill_way;
          fill_index_d = fill_index;
        end
      end
      default: begin
        if (fill_valid) begin
          if (beat_q == CW'(NB - 1)) begin
            state_d     = ST_IDLE;
            beat_d      = '0;
            fill_done_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    rd_off    = 0;
    wr_rel    = 0;
    for (int j = 0; j < RB; j++) begin
      rd_off = (int'(rd_offset) + j) & (LINE_BYTES - 1);
      wr_rel = (rd_off - int'(wr_offset)) & (LINE_BYTES - 1);
      if (cpu_we && wr_line == rd_line && wr_rel < int'(wr_len)) begin
        rd_data_d[8*j +: 8] = wr_data[8*(wr_rel & 7) +: 8];
      end else begin
        rd_data_d[8*j +: 8] = mem_q[byte_addr(rd_line, rd_off)];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (cpu_we && i < int'(wr_len)) begin
        mem_q[byte_addr(wr_line, int'(wr_offset) + i)] <= wr_data[8*i +: 8];
      end
    end
    if (fill_beat_we) begin
      for (int b = 0; b < FB; b++) begin
        mem_q[byte_addr(fill_line, int'(beat_q) * FB + b)] <= fill_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      fill_way_q   <= '0;
      fill_index_q <= '0;
      fill_done_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      fill_way_q   <= fill_way_d;
      fill_index_q <= fill_index_d;
      fill_done_q  <= fill_done_d;
      rd_valid_q   <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fill_ready = (state_q == ST_FILL);
  assign busy       = (state_q == ST_FILL);
  assign fill_done  = fill_done_q;

endmodule
